pwm_dead_time_gen: RTL and testbench

- Downstream consumer of the multiplied clock produced by the clock block.
- Runs entirely in the Multiplied_Clk_Out domain.
- Generates a complementary PWM pair, PWM_High and PWM_Low, with programmable period, duty and dead time.
- Period, duty and dead time are double-buffered: software-side loads go into shadow registers and transfer to the active registers only at a period boundary, so no output glitches occur.

---
 rtl/pwm_dead_time_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_pwm_dead_time_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dead_time_gen.sv
// -----------------------------------------------------------------------------
// pwm_dead_time_gen
//
// Complementary PWM pair generator with programmable period, duty and dead
// time. It runs entirely in the multiplied-clock domain (Clk).
//
// Software loads go into shadow registers. They move to the active registers
// only at a period boundary, or at any edge while the block is disabled. A
// period or duty change therefore never shortens or stretches a pulse in
// flight.
//
// Ports
//   Clk           PWM clock (multiplied clock output of the clock block)
//   Reset_n       synchronous active-low reset
//   Enable        run control; 0 holds the counter at 0 and drives both
//                 outputs low
//   Period_In     period length minus 1, in cycles
//   Duty_In       number of raw-high cycles per period
//   Dead_Time_In  both-low gap inserted at each transition, in cycles
//   Load_Req      one-cycle strobe; captures the three inputs into the shadow
//   Load_Ack      one-cycle pulse on the cycle after a capture
//   Pending       shadow holds values not yet moved to the active registers
//   Period_Start  one-cycle pulse marking counter == 0 while enabled,
//                 registered together with the counter
//   PWM_High      high-side drive
//   PWM_Low       low-side drive
// -----------------------------------------------------------------------------
module pwm_dead_time_gen #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic [WIDTH-1:0]    Period_In,
  input  logic [WIDTH-1:0]    Duty_In,
  input  logic [DT_WIDTH-1:0] Dead_Time_In,
  input  logic                Load_Req,
  output logic                Load_Ack,
  output logic                Pending,
  output logic                Period_Start,
  output logic                PWM_High,
  output logic                PWM_Low
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_DEAD    = 2'd1,
    ST_HIGH_ON = 2'd2,
    ST_LOW_ON  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Register declarations
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]    period_sh_q, period_sh_d;
  logic [WIDTH-1:0]    duty_sh_q,   duty_sh_d;
  logic [DT_WIDTH-1:0] dt_sh_q,     dt_sh_d;

  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic [WIDTH-1:0]    duty_act_q,   duty_act_d;
  logic [DT_WIDTH-1:0] dt_act_q,     dt_act_d;

  logic                pending_q,      pending_d;
  logic                load_ack_q,     load_ack_d;
  logic [WIDTH-1:0]    count_q,        count_d;
  logic                period_start_q, period_start_d;

  state_e              state_q, state_d;
  logic [DT_WIDTH-1:0] dead_cnt_q, dead_cnt_d;

  // ---------------------------------------------------------------------------
  // Shared decodes
  // ---------------------------------------------------------------------------
  logic   raw;           // ideal (dead-time-free) high-side request
  logic   at_end;        // counter sits on the last cycle of the period
  logic   transfer;      // shadow -> active on this edge
  logic   dt_zero;       // no dead time configured
  state_e raw_on_state;  // on-state matching the current raw level

  always_comb begin
    raw          = (count_q < duty_act_q);
    at_end       = (count_q == period_act_q);
    // While disabled the outputs are already low, so applying new values
    // immediately cannot glitch anything.
    transfer     = (Enable && at_end) || !Enable;
    dt_zero      = (dt_act_q == '0);
    raw_on_state = raw ? ST_HIGH_ON : ST_LOW_ON;
  end

  // ---------------------------------------------------------------------------
  // Shadow / active registers, load handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    period_sh_d  = period_sh_q;
    duty_sh_d    = duty_sh_q;
    dt_sh_d      = dt_sh_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    dt_act_d     = dt_act_q;
    pending_d    = pending_q;

    // The active registers take the shadow content from before this edge.
    // A load on the same edge lands in the shadow and keeps Pending set,
    // so the capture always wins over the transfer.
    if (transfer) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
      dt_act_d     = dt_sh_q;
      pending_d    = 1'b0;
    end

    if (Load_Req) begin
      period_sh_d = Period_In;
      duty_sh_d   = Duty_In;
      dt_sh_d     = Dead_Time_In;
      pending_d   = 1'b1;
    end

    load_ack_d = Load_Req;
  end

  // ---------------------------------------------------------------------------
  // Period counter and period-start marker
  // ---------------------------------------------------------------------------
  always_comb begin
    // The wrap compares against the period that is active now. A pending
    // period only takes effect from the following count of 0.
    if (!Enable || at_end) begin
      count_d = '0;
    end else begin
      count_d = count_q + WIDTH'(1);
    end

    // Registered from the current count, so the marker lines up with the
    // first output cycle that reflects count 0.
    period_start_d = Enable && (count_q == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      period_sh_q    <= '0;
      duty_sh_q      <= '0;
      dt_sh_q        <= '0;
      period_act_q   <= '0;
      duty_act_q     <= '0;
      dt_act_q       <= '0;
      pending_q      <= 1'b0;
      load_ack_q     <= 1'b0;
      count_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_sh_q    <= period_sh_d;
      duty_sh_q      <= duty_sh_d;
      dt_sh_q        <= dt_sh_d;
      period_act_q   <= period_act_d;
      duty_act_q     <= duty_act_d;
      dt_act_q       <= dt_act_d;
      pending_q      <= pending_d;
      load_ack_q     <= load_ack_d;
      count_q        <= count_d;
      period_start_q <= period_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output state machine: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_OFF;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output state machine: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;

    if (!Enable) begin
      state_d    = ST_OFF;
      dead_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (dt_zero) begin
            state_d = raw_on_state;
          end else begin
            state_d    = ST_DEAD;
            dead_cnt_d = dt_act_q;
          end
        end

        ST_HIGH_ON: begin
          if (!raw) begin
            if (dt_zero) begin
              state_d = ST_LOW_ON;
            end else begin
              state_d    = ST_DEAD;
              dead_cnt_d = dt_act_q;
            end
          end
        end

        ST_LOW_ON: begin
          if (raw) begin
            if (dt_zero) begin
              state_d = ST_HIGH_ON;
            end else begin
              state_d    = ST_DEAD;
              dead_cnt_d = dt_act_q;
            end
          end
        end

        ST_DEAD: begin
          // The counter holds the number of DEAD cycles still to spend,
          // including the current one. Raw is only looked at on the final
          // cycle, so raw toggling inside the gap does not restart it.
          if (dead_cnt_q <= DT_WIDTH'(1)) begin
            state_d    = raw_on_state;
            dead_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q - DT_WIDTH'(1);
          end
        end

        default: begin
          state_d    = ST_OFF;
          dead_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output state machine: output decode
  // ---------------------------------------------------------------------------
  // Each drive decodes from a single registered state, so both drives can
  // never be high together, not even for one cycle.
  always_comb begin
    PWM_High = (state_q == ST_HIGH_ON);
    PWM_Low  = (state_q == ST_LOW_ON);
  end

  assign Load_Ack     = load_ack_q;
  assign Pending      = pending_q;
  assign Period_Start = period_start_q;

endmodule

// File: tb/tb_pwm_dead_time_gen.sv
`timescale 1ns/1ps
module tb_pwm_dead_time_gen;

  localparam int W  = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [W-1:0]  per_in;
  logic [W-1:0]  duty_in;
  logic [DW-1:0] dt_in;
  logic          ack, pend, ps, hi, lo;

  always #5 clk = ~clk;

  pwm_dead_time_gen #(.WIDTH(W), .DT_WIDTH(DW)) dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .Enable       (en),
    .Period_In    (per_in),
    .Duty_In      (duty_in),
    .Dead_Time_In (dt_in),
    .Load_Req     (load),
    .Load_Ack     (ack),
    .Pending      (pend),
    .Period_Start (ps),
    .PWM_High     (hi),
    .PWM_Low      (lo)
  );

  typedef struct packed {
    logic ack;
    logic pend;
    logic ps;
    logic hi;
    logic lo;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   pushed = 0;
  int   popped = 0;

  // Behavioural reference model, written directly from the block's rules.
  int m_cnt = 0, m_per = 0, m_duty = 0, m_dt = 0;
  int s_per = 0, s_duty = 0, s_dt = 0;
  int m_dead = 0;   // DEAD cycles still to spend (0: not in a gap)
  bit m_hi = 0, m_lo = 0, m_pend = 0, m_ack = 0, m_ps = 0;

  function automatic void model_step(input bit r, input bit e, input bit l,
                                     input int p, input int d, input int t);
    bit raw;
    bit wrap;
    if (!r) begin
      m_cnt = 0; m_per = 0; m_duty = 0; m_dt = 0;
      s_per = 0; s_duty = 0; s_dt = 0;
      m_dead = 0; m_hi = 0; m_lo = 0; m_pend = 0; m_ack = 0; m_ps = 0;
      return;
    end
    raw  = (m_cnt < m_duty);
    wrap = (m_cnt == m_per);
    m_ps = e && (m_cnt == 0);
    if (!e) begin
      m_hi = 0; m_lo = 0; m_dead = 0;
    end else if (m_dead > 0) begin
      if (m_dead == 1) begin
        m_dead = 0; m_hi = raw; m_lo = !raw;
      end else begin
        m_dead = m_dead - 1;
      end
    end else if (!m_hi && !m_lo) begin
      if (m_dt == 0) begin m_hi = raw; m_lo = !raw; end
      else m_dead = m_dt;
    end else if (m_hi && !raw) begin
      m_hi = 0;
      if (m_dt == 0) m_lo = 1; else m_dead = m_dt;
    end else if (m_lo && raw) begin
      m_lo = 0;
      if (m_dt == 0) m_hi = 1; else m_dead = m_dt;
    end
    m_cnt = (!e || wrap) ? 0 : m_cnt + 1;
    if (!e || wrap) begin
      m_per = s_per; m_duty = s_duty; m_dt = s_dt; m_pend = 0;
    end
    if (l) begin
      s_per = p; s_duty = d; s_dt = t; m_pend = 1;
    end
    m_ack = l;
  endfunction

  // One clock of stimulus: drive on the falling edge, predict, enqueue.
  task automatic cyc(input bit r, input bit e, input bit l,
                     input int p, input int d, input int t);
    exp_t ev;
    @(negedge clk);
    rst_n   = r;
    en      = e;
    load    = l;
    per_in  = W'(p);
    duty_in = W'(d);
    dt_in   = DW'(t);
    model_step(r, e, l, p, d, t);
    ev.ack  = m_ack;
    ev.pend = m_pend;
    ev.ps   = m_ps;
    ev.hi   = m_hi;
    ev.lo   = m_lo;
    exp_q.push_back(ev);
    pushed++;
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) cyc(1'b1, e, 1'b0, 0, 0, 0);
  endtask

  task automatic ld(input bit e, input int p, input int d, input int t);
    cyc(1'b1, e, 1'b1, p, d, t);
  endtask

  task automatic chk(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expected response per clock, compared just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        chk("load_ack",     ack,      e.ack);
        chk("pending",      pend,     e.pend);
        chk("period_start", ps,       e.ps);
        chk("pwm_high",     hi,       e.hi);
        chk("pwm_low",      lo,       e.lo);
        chk("no_overlap",   hi && lo, 1'b0);
        if (ack === 1'b1)
          $display("load acknowledged t=%0t pending=%b", $time, pend);
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    per_in = '0; duty_in = '0; dt_in = '0;

    // Reset
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
    run(2, 1'b0);

    // Period 9, duty 4, no dead time
    ld(1'b0, 9, 4, 0);
    run(2, 1'b0);
    run(32, 1'b1);

    // Same with dead time 2 (takes effect at the wrap)
    ld(1'b1, 9, 4, 2);
    run(40, 1'b1);

    // Edge duties
    ld(1'b1, 9, 0, 3);
    run(35, 1'b1);
    ld(1'b1, 9, 10, 2);
    run(35, 1'b1);

    // Mid-period load at count 3, then overwrite before the wrap
    ld(1'b1, 9, 4, 0);
    run(12, 1'b1);
    for (int k = 0; k < 30 && m_cnt != 3; k++) run(1, 1'b1);
    ld(1'b1, 4, 2, 0);
    run(2, 1'b1);
    ld(1'b1, 4, 3, 0);
    run(25, 1'b1);

    // Enable dropped mid-period, then re-enabled with dead time
    ld(1'b1, 9, 4, 3);
    run(14, 1'b1);
    run(3, 1'b0);
    run(20, 1'b1);

    // Reset mid-operation
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    run(3, 1'b1);
    ld(1'b0, 9, 4, 3);
    run(20, 1'b1);

    // One-cycle period
    ld(1'b0, 0, 1, 0);
    run(12, 1'b1);

    // Dead time wider than the pulse
    ld(1'b0, 9, 2, 5);
    run(50, 1'b1);

    // Large duty against a short period (unsigned compare)
    ld(1'b1, 6, 16'hFFFF, 1);
    run(20, 1'b1);

    // Randomized operation
    for (int i = 0; i < 700; i++) begin
      bit r, e, l;
      int p, d, t;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 24) != 0);
      l = ($urandom_range(0, 14) == 0);
      p = $urandom_range(0, 12);
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535)
                                      : $urandom_range(0, p + 2);
      t = $urandom_range(0, 4);
      cyc(r, e, l, p, d, t);
    end

    run(2, 1'b1);
    @(posedge clk);
    #3;
    total++;
    if (popped != pushed || exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: popped %0d expected %0d", popped, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
